// File: rtl/fg_pkg.sv
// fg_pkg: shared state codes, answer table and helpers for the factorization quiz
// Holds the STATE encodings also used by the 7-segment decoders, the state type,
// the smallest-prime-factor answer table and a small max helper for timer sizing.
package fg_pkg;

   localparam logic [3:0] ST_IDLE     = 4'b0000;
   localparam logic [3:0] ST_READY    = 4'b0010;
   localparam logic [3:0] ST_QUESTION = 4'b0011;
   localparam logic [3:0] ST_INPUT    = 4'b0100;
   localparam logic [3:0] ST_DRAW     = 4'b0110;
   localparam logic [3:0] ST_WRONG    = 4'b0111;
   localparam logic [3:0] ST_GOOD     = 4'b1000;
   localparam logic [3:0] ST_OUCH     = 4'b1001;
   localparam logic [3:0] ST_WIN      = 4'b1010;
   localparam logic [3:0] ST_LOSE     = 4'b1011;

   typedef enum logic [3:0] {
      S_IDLE     = ST_IDLE,
      S_READY    = ST_READY,
      S_QUESTION = ST_QUESTION,
      S_INPUT    = ST_INPUT,
      S_DRAW     = ST_DRAW,
      S_WRONG    = ST_WRONG,
      S_GOOD     = ST_GOOD,
      S_OUCH     = ST_OUCH,
      S_WIN      = ST_WIN,
      S_LOSE     = ST_LOSE
   } fg_state_e;

   // Entry [q] is the DIN code of the smallest prime factor of q (leftmost is q=9).
   localparam logic [9:0][3:0] ANS = {4'd2, 4'd1, 4'd4, 4'd1, 4'd3,
                                      4'd1, 4'd2, 4'd1, 4'd5, 4'd0};

   function automatic logic [3:0] ans_of(input logic [3:0] q);
      return (q > 4'd9) ? 4'd0 : ANS[q];
   endfunction

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fg_timer.sv
// fg_timer: loadable down-counter that pulses expire_o in the last cycle of a load
// Ports: clk_i, rst_i (sync, active-high), load_i + value_i (W bits) restart the count,
//   expire_o is high while the count is 1, so a load of N spans exactly N cycles.
module fg_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] value_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load_i ? value_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: round sequencer for the factorization quiz
// Ports: CLK, RST (sync, active-high), START/ENTER one-cycle button pulses, DIN answer code;
//   STATE, QUE, DIN_Q, SCORE, ROUND and BUSY are registered outputs to the decoders.
// Build option: FACTOR_CTRL_PENALTY_EN makes entry to WRONG/OUCH cost one point (floor 0).
module factor_game_ctrl
   import fg_pkg::*;
#(
   parameter int unsigned READY_CYC  = 50_000_000,
   parameter int unsigned SHOW_CYC   = 25_000_000,
   parameter int unsigned INPUT_CYC  = 250_000_000,
   parameter int unsigned RESULT_CYC = 50_000_000,
   parameter int unsigned ROUNDS     = 5,
   parameter int unsigned WIN_SCORE  = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       ENTER,
   input  logic [3:0] DIN,
   output fg_state_e  STATE,
   output logic [3:0] QUE,
   output logic [3:0] DIN_Q,
   output logic [2:0] SCORE,
   output logic [2:0] ROUND,
   output logic       BUSY
);

   localparam int unsigned MAXC = max2(max2(READY_CYC, SHOW_CYC), max2(INPUT_CYC, RESULT_CYC));
   localparam int TW = $clog2(MAXC + 1);

   fg_state_e   state_q, state_d, verdict;
   logic [3:0]  que_q, que_d, din_q_q, qcnt_q, qcnt_d;
   logic [2:0]  score_q, score_d, round_q, round_d, score_up, score_dn, round_inc;
   logic        busy_q, busy_d, hit, tmr_load, expire;
   logic [TW-1:0] tmr_val;

   fg_timer #(.W(TW)) u_timer (
      .clk_i    (CLK),
      .rst_i    (RST),
      .load_i   (tmr_load),
      .value_i  (tmr_val),
      .expire_o (expire)
   );

   assign hit       = (DIN == ans_of(que_q));
   assign score_up  = (score_q == 3'd7) ? score_q : score_q + 3'd1;
`ifdef FACTOR_CTRL_PENALTY_EN
   assign score_dn  = (score_q == 3'd0) ? score_q : score_q - 3'd1;
`else
   assign score_dn  = score_q;
`endif
   assign round_inc = round_q + 3'd1;
   assign verdict   = (score_q > 3'(WIN_SCORE)) ? S_WIN :
                      (score_q == 3'(WIN_SCORE)) ? S_DRAW : S_LOSE;
   // Free-running 0..9 source of question digits, independent of the game.
   assign qcnt_d    = (qcnt_q == 4'd9) ? 4'd0 : qcnt_q + 4'd1;

   always_comb begin
      state_d  = state_q;
      que_d    = que_q;
      score_d  = score_q;
      round_d  = round_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         S_IDLE, S_WIN, S_DRAW, S_LOSE: begin
            if (START) begin
               state_d  = S_READY;
               score_d  = '0;
               round_d  = '0;
               tmr_load = 1'b1;
               tmr_val  = TW'(READY_CYC);
            end
         end
         S_READY: begin
            if (expire) begin
               state_d  = S_QUESTION;
               que_d    = qcnt_q;
               tmr_load = 1'b1;
               tmr_val  = TW'(SHOW_CYC);
            end
         end
         S_QUESTION: begin
            if (expire) begin
               state_d  = S_INPUT;
               tmr_load = 1'b1;
               tmr_val  = TW'(INPUT_CYC);
            end
         end
         S_INPUT: begin
            // ENTER wins over a simultaneous window expiry.
            if (ENTER || expire) begin
               state_d  = !ENTER ? S_OUCH : hit ? S_GOOD : S_WRONG;
               score_d  = (ENTER && hit) ? score_up : score_dn;
               tmr_load = 1'b1;
               tmr_val  = TW'(RESULT_CYC);
            end
         end
         S_GOOD, S_WRONG, S_OUCH: begin
            if (expire) begin
               round_d = round_inc;
               if (round_inc == 3'(ROUNDS)) state_d = verdict;
               else begin
                  state_d  = S_QUESTION;
                  que_d    = qcnt_q;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(SHOW_CYC);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb busy_d = !(state_d inside {S_IDLE, S_WIN, S_DRAW, S_LOSE});

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         que_q   <= '0;
         din_q_q <= '0;
         score_q <= '0;
         round_q <= '0;
         busy_q  <= 1'b0;
         qcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         que_q   <= que_d;
         din_q_q <= (state_q == S_INPUT) ? DIN : din_q_q;
         score_q <= score_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         qcnt_q  <= qcnt_d;
      end
   end

   assign STATE = state_q;
   assign QUE   = que_q;
   assign DIN_Q = din_q_q;
   assign SCORE = score_q;
   assign ROUND = round_q;
   assign BUSY  = busy_q;

endmodule

// File: tb/tb_factor_game_ctrl.sv
// tb_factor_game_ctrl: table-driven directed checks of the quiz sequencer
module tb_factor_game_ctrl;
   import fg_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic       ENTER = 1'b0;
   logic [3:0] DIN = 4'd0;
   fg_state_e  STATE;
   logic [3:0] QUE, DIN_Q;
   logic [2:0] SCORE, ROUND;
   logic       BUSY;

`ifdef FACTOR_CTRL_PENALTY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif

   factor_game_ctrl #(
      .READY_CYC(4), .SHOW_CYC(3), .INPUT_CYC(8), .RESULT_CYC(2), .ROUNDS(3), .WIN_SCORE(2)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .ENTER(ENTER), .DIN(DIN),
      .STATE(STATE), .QUE(QUE), .DIN_Q(DIN_Q), .SCORE(SCORE), .ROUND(ROUND), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       st;
      logic       en;
      logic [3:0] din;
      int         n;
      logic [3:0] est;
      logic [3:0] eque;
      logic [2:0] esc;
      logic [2:0] erd;
      logic       eb;
      logic [3:0] edq;
   } vec_t;

   vec_t v[$];
   int tests = 0;
   int fails = 0;

   function automatic void add(logic st, logic en, logic [3:0] din, int n, logic [3:0] est,
                               logic [3:0] eque, logic [2:0] esc, logic [2:0] erd, logic eb,
                               logic [3:0] edq);
      vec_t t;
      t = '{st, en, din, n, est, eque, esc, erd, eb, edq};
      v.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [3:0] est, input logic [3:0] eque,
                            input logic [2:0] esc, input logic [2:0] erd, input logic eb,
                            input logic [3:0] edq);
      chk({nm, ".state"}, 8'(STATE), 8'(est));
      chk({nm, ".que"},   8'(QUE),   8'(eque));
      chk({nm, ".score"}, 8'(SCORE), 8'(esc));
      chk({nm, ".round"}, 8'(ROUND), 8'(erd));
      chk({nm, ".busy"},  8'(BUSY),  8'(eb));
      chk({nm, ".din_q"}, 8'(DIN_Q), 8'(edq));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Cycle c below is counted from the first cycle after reset; question counter = c mod 10.
      // Game 1: OUCH, GOOD (QUE 7), WRONG (QUE 9) -> LOSE
      add(0,0,0,10, ST_IDLE,     0, 0, 0, 0, 0); // c10
      add(1,0,0, 1, ST_READY,    0, 0, 0, 1, 0); // c11
      add(0,0,0, 3, ST_READY,    0, 0, 0, 1, 0); // c14
      add(0,0,0, 1, ST_QUESTION, 4, 0, 0, 1, 0); // c15
      add(0,0,0, 2, ST_QUESTION, 4, 0, 0, 1, 0); // c17
      add(0,0,3, 1, ST_INPUT,    4, 0, 0, 1, 0); // c18
      add(0,0,3, 1, ST_INPUT,    4, 0, 0, 1, 3); // c19
      add(0,0,6, 6, ST_INPUT,    4, 0, 0, 1, 6); // c25 last window cycle
      add(0,0,6, 1, ST_OUCH,     4, 0, 0, 1, 6); // c26
      add(0,0,2, 1, ST_OUCH,     4, 0, 0, 1, 6); // c27 DIN_Q frozen
      add(0,1,4, 1, ST_QUESTION, 7, 0, 1, 1, 6); // c28 ENTER ignored
      add(1,0,4, 2, ST_QUESTION, 7, 0, 1, 1, 6); // c30 START ignored
      add(0,0,4, 1, ST_INPUT,    7, 0, 1, 1, 6); // c31
      add(1,0,4, 6, ST_INPUT,    7, 0, 1, 1, 4); // c37 START ignored
      add(0,1,4, 1, ST_GOOD,     7, 1, 1, 1, 4); // c38
      add(0,0,0, 1, ST_GOOD,     7, 1, 1, 1, 4); // c39
      add(0,0,0, 1, ST_QUESTION, 9, 1, 2, 1, 4); // c40
      add(0,0,1, 3, ST_INPUT,    9, 1, 2, 1, 4); // c43
      add(0,1,1, 1, ST_WRONG,    9, PEN ? 3'd0 : 3'd1, 2, 1, 1); // c44
      add(0,0,0, 1, ST_WRONG,    9, PEN ? 3'd0 : 3'd1, 2, 1, 1); // c45
      add(0,0,0, 1, ST_LOSE,     9, PEN ? 3'd0 : 3'd1, 3, 0, 1); // c46
      add(0,0,0, 5, ST_LOSE,     9, PEN ? 3'd0 : 3'd1, 3, 0, 1); // c51
      // Game 2: three correct, first one on the window's expiry cycle -> WIN
      add(1,0,0, 1, ST_READY,    9, 0, 0, 1, 1); // c52
      add(0,0,0, 3, ST_READY,    9, 0, 0, 1, 1); // c55
      add(0,0,0, 1, ST_QUESTION, 5, 0, 0, 1, 1); // c56
      add(0,0,3, 3, ST_INPUT,    5, 0, 0, 1, 1); // c59
      add(0,0,3, 7, ST_INPUT,    5, 0, 0, 1, 3); // c66 expiry cycle
      add(0,1,3, 1, ST_GOOD,     5, 1, 0, 1, 3); // c67
      add(0,0,0, 2, ST_QUESTION, 8, 1, 1, 1, 3); // c69
      add(0,0,1, 3, ST_INPUT,    8, 1, 1, 1, 3); // c72
      add(0,1,1, 1, ST_GOOD,     8, 2, 1, 1, 1); // c73
      add(0,0,0, 2, ST_QUESTION, 4, 2, 2, 1, 1); // c75
      add(0,0,1, 3, ST_INPUT,    4, 2, 2, 1, 1); // c78
      add(0,1,1, 1, ST_GOOD,     4, 3, 2, 1, 1); // c79
      add(0,0,0, 2, ST_WIN,      4, 3, 3, 0, 1); // c81
      // Game 3: two correct, one wrong -> DRAW (LOSE with penalty)
      add(1,0,0, 1, ST_READY,    4, 0, 0, 1, 1); // c82
      add(0,0,0, 4, ST_QUESTION, 5, 0, 0, 1, 1); // c86
      add(0,0,3, 3, ST_INPUT,    5, 0, 0, 1, 1); // c89
      add(0,1,3, 1, ST_GOOD,     5, 1, 0, 1, 3); // c90
      add(0,0,0, 2, ST_QUESTION, 1, 1, 1, 1, 3); // c92
      add(0,0,5, 3, ST_INPUT,    1, 1, 1, 1, 3); // c95
      add(0,1,5, 1, ST_GOOD,     1, 2, 1, 1, 5); // c96
      add(0,0,0, 2, ST_QUESTION, 7, 2, 2, 1, 5); // c98
      add(0,0,0, 3, ST_INPUT,    7, 2, 2, 1, 5); // c101
      add(0,1,0, 1, ST_WRONG,    7, PEN ? 3'd1 : 3'd2, 2, 1, 0); // c102
      add(0,0,0, 2, PEN ? ST_LOSE : ST_DRAW, 7, PEN ? 3'd1 : 3'd2, 3, 0, 0); // c104
      add(1,0,0, 1, ST_READY,    7, 0, 0, 1, 0); // c105
      add(0,0,9, 7, ST_INPUT,    8, 0, 0, 1, 0); // c112

      step(3);
      RST = 1'b0;
      check_all("reset", ST_IDLE, 0, 0, 0, 0, 0);

      foreach (v[i]) begin
         START = v[i].st;
         ENTER = v[i].en;
         DIN   = v[i].din;
         step(1);
         START = 1'b0;
         ENTER = 1'b0;
         step(v[i].n - 1);
         check_all($sformatf("v%0d", i), v[i].est, v[i].eque, v[i].esc, v[i].erd, v[i].eb,
                   v[i].edq);
      end

      // Mid-game reset during INPUT
      step(1);
      check_all("pre_rst", ST_INPUT, 8, 0, 0, 1, 9);
      RST = 1'b1;
      step(1);
      check_all("mid_rst", ST_IDLE, 0, 0, 0, 0, 0);
      RST = 1'b0;
      // Question counter restarted: START in cycle 10 again yields QUE 4
      step(10);
      START = 1'b1;
      step(1);
      START = 1'b0;
      check_all("restart_ready", ST_READY, 0, 0, 0, 1, 0);
      step(4);
      check_all("restart_que", ST_QUESTION, 4, 0, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
